dmem_loader: RTL

DMEM_LOADER -- requirements
Module: dmem_loader

---
 rtl/dmem_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_loader.sv
// dmem_loader: streams bytes into data memory as big-endian words, otherwise passes the CPU port through.
// Define DMEM_LOADER_CHECKSUM_EN to add a running sum of the words written by each load.
`ifndef DATA_W
`define DATA_W 32
`endif

module dmem_loader (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        base,
    input  logic [15:0]        len,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic [15:0]        cpu_a,
    input  logic [`DATA_W-1:0] cpu_wd,
    input  logic               cpu_we,
    output logic [15:0]        mem_a,
    output logic [`DATA_W-1:0] mem_wd,
    output logic               mem_we,
    output logic               busy,
`ifdef DMEM_LOADER_CHECKSUM_EN
    output logic [`DATA_W-1:0] checksum,
`endif
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e               state_q;
    logic [15:0]          base_q;
    logic [15:0]          len_q;
    logic [15:0]          word_cnt_q;
    logic [1:0]           byte_cnt_q;
    logic [`DATA_W-1:0]   shift_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 in_ready_q;
    logic                 wr_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [`DATA_W-1:0]   checksum_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
`ifdef DMEM_LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q     <= base;
                        len_q      <= len;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        shift_q    <= '0;
                        busy_q     <= 1'b1;
`ifdef DMEM_LOADER_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                        if (len != 16'd0) begin
                            state_q    <= StLoad;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    // in_ready_q is always set in this state, so in_valid alone qualifies a byte
                    if (in_valid) begin
                        shift_q    <= {shift_q[`DATA_W-9:0], in_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= StWrite;
                            in_ready_q <= 1'b0;
                            wr_q       <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    word_cnt_q <= word_cnt_q + 16'd1;
`ifdef DMEM_LOADER_CHECKSUM_EN
                    checksum_q <= checksum_q + shift_q;
`endif
                    if (word_cnt_q + 16'd1 == len_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= StLoad;
                        in_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // CPU port is only visible while idle; the address adder wraps at 16 bits.
    always_comb begin
        mem_a  = cpu_a;
        mem_wd = cpu_wd;
        mem_we = cpu_we;
        if (busy_q) begin
            mem_a  = base_q + word_cnt_q;
            mem_wd = shift_q;
            mem_we = wr_q;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = in_ready_q;
`ifdef DMEM_LOADER_CHECKSUM_EN
    assign checksum = checksum_q;
`endif

endmodule
